// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter
// Shares one fixed-latency 18x18 unsigned multiplier between NREQ requesters.
// A round-robin arbiter grants at most one request per cycle. The granted
// operands are registered onto mul_a/mul_b, and a {valid, idx} tag travels
// down a shift pipeline. The tag lines up with mul_p MUL_LAT edges later, and
// one edge after that the product is steered back to its requester as a
// one-hot strobe. Results come back in issue order and cannot be stalled.
module mult_share_arbiter #(
    parameter int NREQ    = 4,
    parameter int MUL_LAT = 5,
    parameter int CNT_W   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*18-1:0]   req_a,
    input  logic [NREQ*18-1:0]   req_b,
    output logic [NREQ-1:0]      req_ready,
    input  logic                 hold,
    output logic [17:0]          mul_a,
    output logic [17:0]          mul_b,
    input  logic [35:0]          mul_p,
    output logic [NREQ-1:0]      res_valid,
    output logic [35:0]          res_data,
    output logic [CNT_W-1:0]     inflight
);

    // Requester index width; one spare bit is used for the wrap-around search.
    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    // Upper bound on outstanding operations: one per tag stage.
    localparam logic [CNT_W-1:0] INF_MAX = CNT_W'(MUL_LAT + 1);

    // Unpacked per-requester operands.
    logic [17:0]        op_a [NREQ];
    logic [17:0]        op_b [NREQ];

    // Arbitration results.
    logic               win_found;
    logic [IDX_W-1:0]   win_idx;
    logic [IDX_W:0]     cand;
    logic               transfer;
    logic [NREQ-1:0]    grant_vec;

    // Round-robin pointer: the requester searched first.
    logic [IDX_W-1:0]   rr_ptr_q;
    logic [IDX_W-1:0]   rr_ptr_d;

    // Multiplier operand registers.
    logic [17:0]        mul_a_q;
    logic [17:0]        mul_a_d;
    logic [17:0]        mul_b_q;
    logic [17:0]        mul_b_d;

    // Tag pipeline: stage MUL_LAT lines up with mul_p.
    logic               tag_vld_q [0:MUL_LAT];
    logic [IDX_W-1:0]   tag_idx_q [0:MUL_LAT];

    // Return path.
    logic               ret;
    logic [NREQ-1:0]    res_valid_q;
    logic [NREQ-1:0]    res_valid_d;
    logic [35:0]        res_data_q;
    logic [35:0]        res_data_d;

    // Outstanding operation counter.
    logic [CNT_W-1:0]   inflight_q;
    logic [CNT_W-1:0]   inflight_d;

    // Slice the packed operand buses into per-requester words.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign op_a[gi] = req_a[18*gi +: 18];
            assign op_b[gi] = req_b[18*gi +: 18];
        end
    endgenerate

    // Find the first valid requester starting at rr_ptr, wrapping modulo NREQ.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(NREQ)) begin
                cand = cand - (IDX_W+1)'(NREQ);
            end
            if (!win_found && req_valid[cand[IDX_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[IDX_W-1:0];
            end
        end
    end

    // The winner is always valid, so any unheld winner is a transfer.
    assign transfer = win_found && !hold;

    // One-hot grant decoded from the winner index.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_grant
            assign grant_vec[gi] = transfer && (win_idx == IDX_W'(gi));
        end
    endgenerate

    assign req_ready = grant_vec;

    // Next pointer: one past the granted requester; unchanged without a transfer.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (transfer) begin
            if (win_idx == IDX_W'(NREQ - 1)) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = win_idx + 1'b1;
            end
        end
    end

    // Granted operands go to the multiplier; idle cycles feed zeros.
    always_comb begin
        mul_a_d = '0;
        mul_b_d = '0;
        if (transfer) begin
            mul_a_d = op_a[win_idx];
            mul_b_d = op_b[win_idx];
        end
    end

    // Arbiter pointer and operand registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q <= '0;
            mul_a_q  <= '0;
            mul_b_q  <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            mul_a_q  <= mul_a_d;
            mul_b_q  <= mul_b_d;
        end
    end

    // Tag stage 0 captures the issue decision on the same edge as the operands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_vld_q[0] <= 1'b0;
            tag_idx_q[0] <= '0;
        end else begin
            tag_vld_q[0] <= transfer;
            tag_idx_q[0] <= win_idx;
        end
    end

    // Remaining tag stages shift unconditionally; the multiplier cannot stall.
    generate
        for (genvar gi = 1; gi <= MUL_LAT; gi++) begin : g_tag
            // Shift stage gi-1 into stage gi every edge.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    tag_vld_q[gi] <= 1'b0;
                    tag_idx_q[gi] <= '0;
                end else begin
                    tag_vld_q[gi] <= tag_vld_q[gi-1];
                    tag_idx_q[gi] <= tag_idx_q[gi-1];
                end
            end
        end
    endgenerate

    // A valid tag in the last stage means mul_p holds its product now.
    assign ret = tag_vld_q[MUL_LAT];

    // Steer the strobe to the tagged requester.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_ret
            assign res_valid_d[gi] = ret && (tag_idx_q[MUL_LAT] == IDX_W'(gi));
        end
    endgenerate

    // Products with no valid tag (idle slots, pre-reset leftovers) are masked to 0.
    assign res_data_d = ret ? mul_p : 36'd0;

    // Count up on issue, down on return; a simultaneous pair cancels.
    always_comb begin
        inflight_d = inflight_q;
        if (transfer && !ret) begin
            if (inflight_q != INF_MAX) begin
                inflight_d = inflight_q + 1'b1;
            end
        end else if (!transfer && ret) begin
            if (inflight_q != '0) begin
                inflight_d = inflight_q - 1'b1;
            end
        end
    end

    // Result and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid_q <= '0;
            res_data_q  <= '0;
            inflight_q  <= '0;
        end else begin
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            inflight_q  <= inflight_d;
        end
    end

    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign inflight  = inflight_q;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Bench for mult_share_arbiter: a 5-stage multiplier model sits on the mul_*
// ports. A queue-based reference model predicts grants, operands, result
// strobes and the in-flight count from the arbitration and latency rules.
module tb_mult_share_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [71:0] req_a = '0;
    logic [71:0] req_b = '0;
    logic [3:0]  req_ready;
    logic        hold = 1'b0;
    logic [17:0] mul_a;
    logic [17:0] mul_b;
    logic [35:0] mul_p;
    logic [3:0]  res_valid;
    logic [35:0] res_data;
    logic [3:0]  inflight;

    mult_share_arbiter #(.NREQ(4), .MUL_LAT(5), .CNT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .hold      (hold),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_p     (mul_p),
        .res_valid (res_valid),
        .res_data  (res_data),
        .inflight  (inflight)
    );

    always #5 clk = ~clk;

    // Multiplier: input register plus four stages, no reset (like the hard block).
    logic [35:0] mpipe [0:4];
    always_ff @(posedge clk) begin
        mpipe[0] <= 36'(mul_a) * 36'(mul_b);
        for (int i = 1; i < 5; i++) mpipe[i] <= mpipe[i-1];
    end
    assign mul_p = mpipe[4];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: pending ops with their due edge, plus a pointer.
    typedef struct {
        int          due;
        int          idx;
        logic [35:0] prod;
    } op_t;
    op_t         q[$];
    int          rr_m = 0;
    int          edge_n = 0;
    logic        pend_xfer = 1'b0;
    int          pend_idx = 0;
    logic [17:0] pend_a = '0;
    logic [17:0] pend_b = '0;
    logic [17:0] exp_ma = '0;
    logic [17:0] exp_mb = '0;
    logic [3:0]  exp_rv = '0;
    logic [35:0] exp_rd = '0;
    int          exp_inf = 0;
    logic [3:0]  last_ready;
    int          acc_edge = 0;

    // Apply what the model decided would happen on the edge just taken.
    task automatic model_edge();
        edge_n++;
        if (pend_xfer) begin
            q.push_back('{due: edge_n + 6, idx: pend_idx,
                          prod: 36'(pend_a) * 36'(pend_b)});
            rr_m   = (pend_idx + 1) % 4;
            exp_ma = pend_a;
            exp_mb = pend_b;
        end else begin
            exp_ma = '0;
            exp_mb = '0;
        end
        exp_rv = '0;
        exp_rd = '0;
        if (q.size() > 0 && q[0].due == edge_n) begin
            exp_rv = 4'b0001 << q[0].idx;
            exp_rd = q[0].prod;
            void'(q.pop_front());
        end
        exp_inf = q.size();
    endtask

    // One clock cycle: take the edge, drive new inputs, check at the falling edge.
    task automatic cyc(input logic [3:0] v, input logic h,
                       input logic [71:0] a, input logic [71:0] b);
        logic [3:0] er;
        @(posedge clk);
        model_edge();
        #1;
        req_valid = v;
        hold      = h;
        req_a     = a;
        req_b     = b;
        @(negedge clk);
        er = '0;
        pend_xfer = 1'b0;
        if (!h) begin
            for (int k = 0; k < 4; k++) begin
                int c;
                c = (rr_m + k) % 4;
                if (!pend_xfer && v[c]) begin
                    pend_xfer = 1'b1;
                    pend_idx  = c;
                    er        = 4'b0001 << c;
                end
            end
        end
        if (pend_xfer) begin
            pend_a   = a[18*pend_idx +: 18];
            pend_b   = b[18*pend_idx +: 18];
            acc_edge = edge_n + 1;
        end
        last_ready = req_ready;
        chk("req_ready", 64'(req_ready), 64'(er));
        chk("mul_a", 64'(mul_a), 64'(exp_ma));
        chk("mul_b", 64'(mul_b), 64'(exp_mb));
        chk("res_valid", 64'(res_valid), 64'(exp_rv));
        chk("res_data", 64'(res_data), 64'(exp_rd));
        chk("inflight", 64'(inflight), 64'(exp_inf));
        if (res_valid != 0)
            $display("result edge=%0d valid=%b data=%0h", edge_n, res_valid, res_data);
    endtask

    // Asynchronous reset pulse in the middle of a cycle.
    task automatic do_reset();
        req_valid = '0;
        hold      = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        chk("rst_mul_a", 64'(mul_a), 64'd0);
        chk("rst_res_valid", 64'(res_valid), 64'd0);
        chk("rst_res_data", 64'(res_data), 64'd0);
        chk("rst_inflight", 64'(inflight), 64'd0);
        q.delete();
        rr_m      = 0;
        pend_xfer = 1'b0;
        exp_ma    = '0;
        exp_mb    = '0;
        exp_rv    = '0;
        exp_rd    = '0;
        exp_inf   = 0;
        @(posedge clk);
        #3;
        rst = 1'b0;
    endtask

    function automatic logic [71:0] pack4(input logic [17:0] x0, input logic [17:0] x1,
                                          input logic [17:0] x2, input logic [17:0] x3);
        return {x3, x2, x1, x0};
    endfunction

    function automatic logic [71:0] rnd_ops();
        return {18'($urandom), 18'($urandom), 18'($urandom), 18'($urandom)};
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(4'b0000, 1'b0, '0, '0);
    endtask

    typedef struct packed {
        logic [3:0] v;
        logic       h;
        logic [3:0] exp;
    } vec_t;
    vec_t vecs [12];

    int lat;
    int peak;
    int strobes;
    logic seen;

    initial begin
        // Arbitration sequence from reset (pointer starts at 0).
        vecs[0]  = '{v: 4'b1111, h: 1'b0, exp: 4'b0001};
        vecs[1]  = '{v: 4'b0010, h: 1'b0, exp: 4'b0010};
        vecs[2]  = '{v: 4'b0011, h: 1'b0, exp: 4'b0001};  // ptr=2, wraps to 0
        vecs[3]  = '{v: 4'b0011, h: 1'b0, exp: 4'b0010};
        vecs[4]  = '{v: 4'b0111, h: 1'b0, exp: 4'b0100};  // 2 joins, beats 0
        vecs[5]  = '{v: 4'b0111, h: 1'b0, exp: 4'b0001};
        vecs[6]  = '{v: 4'b1111, h: 1'b1, exp: 4'b0000};
        vecs[7]  = '{v: 4'b1000, h: 1'b0, exp: 4'b1000};
        vecs[8]  = '{v: 4'b0000, h: 1'b0, exp: 4'b0000};
        vecs[9]  = '{v: 4'b1110, h: 1'b0, exp: 4'b0010};
        vecs[10] = '{v: 4'b1100, h: 1'b1, exp: 4'b0000};
        vecs[11] = '{v: 4'b1100, h: 1'b0, exp: 4'b0100};

        do_reset();

        // Single op 3*5: latency 6 edges, product 15.
        cyc(4'b0001, 1'b0, pack4(18'd3, 18'd0, 18'd0, 18'd0), pack4(18'd5, 18'd0, 18'd0, 18'd0));
        lat  = -1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc(4'b0000, 1'b0, '0, '0);
            if (!seen && res_valid != 0) begin
                seen = 1'b1;
                lat  = edge_n - acc_edge;
                chk("t1_res_valid", 64'(res_valid), 64'h1);
                chk("t1_res_data", 64'(res_data), 64'd15);
            end
        end
        chk("t1_latency", 64'(lat), 64'd6);

        // All four requesters streaming A=i+1, B=1000.
        peak = 0;
        for (int i = 0; i < 16; i++) begin
            cyc(4'b1111, 1'b0, pack4(18'd1, 18'd2, 18'd3, 18'd4),
                pack4(18'd1000, 18'd1000, 18'd1000, 18'd1000));
            if (int'(inflight) > peak) peak = int'(inflight);
        end
        chk("t2_peak_inflight", 64'(peak), 64'd6);
        idle(8);

        // Maximum operands.
        cyc(4'b0100, 1'b0, pack4(18'd0, 18'd0, 18'h3FFFF, 18'd0), pack4(18'd0, 18'd0, 18'h3FFFF, 18'd0));
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cyc(4'b0000, 1'b0, '0, '0);
            if (!seen && res_valid != 0) begin
                seen = 1'b1;
                chk("t3_max_product", 64'(res_data), 64'hFFFF80001);
            end
        end
        chk("t3_result_seen", 64'(seen), 64'd1);

        // Table-driven arbitration from a fresh reset.
        do_reset();
        for (int i = 0; i < 12; i++) begin
            cyc(vecs[i].v, vecs[i].h, rnd_ops(), rnd_ops());
            chk($sformatf("tbl_ready[%0d]", i), 64'(last_ready), 64'(vecs[i].exp));
        end
        idle(8);

        // Hold for three cycles after two issued ops: exactly two strobes return.
        strobes = 0;
        for (int i = 0; i < 2; i++) begin
            cyc(4'b1111, 1'b0, rnd_ops(), rnd_ops());
            if (res_valid != 0) strobes++;
        end
        for (int i = 0; i < 3; i++) begin
            cyc(4'b1111, 1'b1, rnd_ops(), rnd_ops());
            if (res_valid != 0) strobes++;
        end
        for (int i = 0; i < 8; i++) begin
            cyc(4'b0000, 1'b0, '0, '0);
            if (res_valid != 0) strobes++;
        end
        chk("t5_strobes", 64'(strobes), 64'd2);

        // Three ops issued, then a reset discards them.
        for (int i = 0; i < 3; i++) cyc(4'b1111, 1'b0, rnd_ops(), rnd_ops());
        cyc(4'b0000, 1'b0, '0, '0);
        chk("t6_inflight_before", 64'(inflight), 64'd3);
        do_reset();
        strobes = 0;
        for (int i = 0; i < 8; i++) begin
            cyc(4'b0000, 1'b0, '0, '0);
            if (res_valid != 0) strobes++;
        end
        chk("t6_no_strobes", 64'(strobes), 64'd0);
        cyc(4'b1111, 1'b0, rnd_ops(), rnd_ops());
        chk("t6_first_grant", 64'(last_ready), 64'h1);
        idle(8);

        // Randomized traffic against the model.
        for (int i = 0; i < 300; i++) begin
            cyc(4'($urandom_range(0, 15)), ($urandom_range(0, 4) == 0),
                rnd_ops(), rnd_ops());
        end
        idle(8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mult_share_arbiter.md
Name: mult_share_arbiter

Overview:
- Shares one 18x18 unsigned pipelined multiplier (fixed latency, no stall input) between NREQ requesters.
- Arbitrates requests round-robin and issues at most one multiply per cycle.
- Tags each issued operation with its requester index and steers the product back to that requester after the multiplier latency.
- Sits between requester datapaths and a single multiplier instance; the multiplier's A/B inputs and product output connect to the mul_* ports.

Parameters:
- NREQ, 4, number of requesters; legal range 2..8.
- MUL_LAT, 5, edges from stable mul_a/mul_b to valid mul_p (input register plus 4 pipeline stages = 5).
- CNT_W, 4, width of inflight; must hold MUL_LAT+1.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester operation request.
- req_a  in  NREQ*18  operand A, requester i at bits [18*i+17:18*i].
- req_b  in  NREQ*18  operand B, same packing.
- req_ready  out  NREQ  one-hot grant; combinational from req_valid, rr_ptr and hold.
- hold  in  1  when 1, no grants this cycle.
- mul_a  out  18  registered operand A to multiplier.
- mul_b  out  18  registered operand B to multiplier.
- mul_p  in  36  multiplier product.
- res_valid  out  NREQ  registered one-hot result strobe.
- res_data  out  36  registered product; meaningful only while res_valid != 0.
- inflight  out  CNT_W  operations issued but not yet returned.

Behaviour:
- Reset (async, rst=1):
  - mul_a, mul_b, res_data, res_valid and inflight go to 0.
  - rr_ptr goes to 0.
  - All tag-pipeline valid bits are cleared.
- Arbitration:
  - The winner is the first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... mod NREQ.
  - req_ready[winner]=1 only if hold=0; otherwise req_ready=0.
  - A transfer occurs on an edge where req_valid[i] & req_ready[i].
  - On a transfer, rr_ptr <= (i+1) mod NREQ. rr_ptr is unchanged when no transfer occurs.
  - A requester may drop req_valid at any time before it is granted. Operands are sampled only on the transfer edge.
- Issue:
  - On a transfer edge t, mul_a/mul_b <= the granted operands.
  - On non-transfer edges, mul_a/mul_b <= 0.
  - The tag pipeline (depth MUL_LAT+1, entries {valid, idx}) shifts every edge. Stage 0 loads {transfer, i}.
- Return:
  - The tag that reaches the last stage at edge t+MUL_LAT aligns with mul_p.
  - At edge t+MUL_LAT+1: res_data <= mul_p, and res_valid <= onehot(idx) if the tag is valid, else 0.
  - Acceptance-to-res_valid latency is MUL_LAT+1 edges (6 by default).
  - Results return in issue order and cannot be back-pressured. Requesters must accept them in the strobe cycle.
  - res_data is 0 when res_valid=0.
- Throughput: one operation per cycle sustained; no bubbles are inserted between back-to-back grants.
- inflight:
  - +1 on a transfer and -1 on a result strobe.
  - Both on the same edge leaves it unchanged.
  - Maximum value is MUL_LAT+1. It never wraps.
- Arithmetic: unsigned 18x18 to 36 bits. The block passes mul_p through untouched.
- Reset mid-operation: in-flight tags are discarded. Products still inside the multiplier after reset release produce no res_valid. inflight restarts at 0.
- hold asserted mid-stream: in-flight operations still complete and return on schedule.
- A single active requester is granted every cycle.

Test Plan:
1. Reset, then req_valid=0001, A0=3, B0=5 for one cycle → req_ready=0001 at once. mul_a=3 after 1 edge. res_valid=0001 with res_data=15 exactly 6 edges after acceptance. inflight goes 1 then back to 0.
2. All four requesters valid continuously, A=i+1, B=1000 → grants cycle 0,1,2,3,0,... one per cycle. res_valid rotates 0001,0010,0100,1000 with res_data 1000,2000,3000,4000. inflight saturates at 6.
3. Max operands A=B=18'h3FFFF → res_data=36'hFFFF80001.
4. rr_ptr=2 with req_valid=0011 → requester 0 granted, then requester 1 (wrap-around). Requester 2 joins the next cycle → it wins over requester 0.
5. hold=1 for 3 cycles during a stream of 2 issued ops → req_ready=0 throughout. Both issued results still return on time. No new res_valid appears for the held cycles.
6. Three ops issued, rst pulsed for one cycle asynchronously between edges → outputs go to 0 immediately. No res_valid for the discarded ops. inflight=0. The next request is granted to requester 0 first.
